// File: rtl/expr_stream_arbiter.sv
// Round-robin owner of a shared expression checker: grants one requester a whole ';'-terminated
// string, steps the grammar checker on its characters and reports a tagged one-cycle verdict.
//
//   state    | meaning
//   S_IDLE   | no owner; pick next requester after rr_ptr
//   S_STREAM | owner's characters consumed into checker until ';'
//   S_REPORT | verdict strobe, owner becomes rr_ptr
module expr_stream_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int MAXLEN = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_char,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 res_valid,
  output logic                 res_ok,
  output logic [IDW-1:0]       res_id
);

  localparam int LENW = $clog2(MAXLEN + 2);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_REPORT} top_state_t;
  typedef enum logic [1:0] {C_START, C_NUM, C_OP, C_ERR} chk_state_t;

  top_state_t      state;
  chk_state_t      chk;
  chk_state_t      chk_next;
  logic [LENW-1:0] len;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  rr_ptr;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  cand;
  logic [7:0]      own_char;
  logic            own_valid;
  logic            is_digit;
  logic            is_op;
  logic            is_semi;

  assign own_char  = req_char[{owner, 3'b000} +: 8];
  assign own_valid = req_valid[owner];
  assign is_digit  = (own_char >= 8'h30) && (own_char <= 8'h39);
  assign is_op     = (own_char == 8'h2B) || (own_char == 8'h2A);
  assign is_semi   = (own_char == 8'h3B);

  assign req_ready = (state == S_STREAM) ? grant : '0;
  assign busy      = (state != S_IDLE);

  // Search starts just after the last owner so continuous requesters rotate fairly.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    chk_next = C_ERR;
    case (chk)
      C_START: chk_next = is_digit ? C_NUM : C_ERR;
      C_NUM:   chk_next = is_digit ? C_NUM : (is_op ? C_OP : C_ERR);
      C_OP:    chk_next = is_digit ? C_NUM : C_ERR;
      default: chk_next = C_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      res_id    <= '0;
      len       <= '0;
      chk       <= C_START;
      owner     <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant <= NREQ'(1) << pick_idx;
            owner <= pick_idx;
            len   <= '0;
            chk   <= C_START;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (own_valid) begin
            if (is_semi) begin
              res_valid <= 1'b1;
              res_ok    <= (chk == C_NUM) && (len <= LENW'(MAXLEN));
              res_id    <= owner;
              state     <= S_REPORT;
            end else begin
              // Saturating one past the limit is enough to remember "too long".
              if (len <= LENW'(MAXLEN)) len <= len + LENW'(1);
              chk <= chk_next;
            end
          end
        end
        S_REPORT: begin
          res_valid <= 1'b0;
          rr_ptr    <= owner;
          grant     <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_stream_arbiter.sv
// Scoreboard bench for expr_stream_arbiter: per-requester character queues feed the DUT,
// expected verdicts come from an independent grammar model and are matched in order.
module tb_expr_stream_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int MAXLEN = 16;

  logic                clk = 1'b0;
  logic                clr_n;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_char;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                res_valid;
  logic                res_ok;
  logic [IDW-1:0]      res_id;

  logic [7:0]   cq [NREQ][$];
  logic [IDW:0] sb [$];
  int errs = 0;
  int checks = 0;
  int verdicts = 0;

  always #5 clk = ~clk;

  expr_stream_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_char(req_char),
    .req_ready(req_ready), .grant(grant), .busy(busy), .res_valid(res_valid),
    .res_ok(res_ok), .res_id(res_id)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Independent grammar model: string s includes its terminating ';'.
  function automatic logic ref_ok(input string s);
    int n;
    logic after_op;
    logic [7:0] c;
    n = s.len() - 1;
    after_op = 1'b1;
    if (n < 1 || n > MAXLEN) return 1'b0;
    for (int k = 0; k < n; k++) begin
      c = s[k];
      if (c >= 8'h30 && c <= 8'h39) after_op = 1'b0;
      else if (c == 8'h2B || c == 8'h2A) begin
        if (after_op) return 1'b0;
        after_op = 1'b1;
      end else return 1'b0;
    end
    return !after_op;
  endfunction

  task automatic send(input int id, input string s, input bit track);
    logic [IDW:0] e;
    for (int k = 0; k < s.len(); k++) cq[id].push_back(s[k]);
    if (track) begin
      e = {id[IDW-1:0], ref_ok(s)};
      sb.push_back(e);
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0) && !busy;
    for (int i = 0; i < NREQ; i++) if (cq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (!all_idle() && n < max) begin @(negedge clk); n++; end
    check_val(tag, all_idle(), 1);
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] g, input int max, input string tag);
    int n = 0;
    while (grant !== g && n < max) begin @(negedge clk); n++; end
    check_val(tag, grant, g);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_grant"}, grant, 0);
    check_val({pfx, "_ready"}, req_ready, 0);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_res_valid"}, res_valid, 0);
    check_val({pfx, "_res_ok"}, res_ok, 0);
    check_val({pfx, "_res_id"}, res_id, 0);
  endtask

  // Driver: a head char is consumed when valid&ready held before the posedge.
  initial begin
    logic [NREQ-1:0] hs;
    req_valid = '0;
    req_char  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready & {NREQ{clr_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        req_valid[i] = (cq[i].size() > 0);
        req_char[8*i +: 8] = (cq[i].size() > 0) ? cq[i][0] : 8'h00;
      end
    end
  end

  // Monitor: grant one-hot every cycle, verdicts matched against the scoreboard.
  initial begin
    logic [IDW:0] e;
    forever begin
      @(negedge clk);
      if (clr_n === 1'b1) begin
        check_val("grant_onehot", ($countones(grant) <= 1), 1);
        if (res_valid) begin
          verdicts++;
          if (sb.size() == 0) check_val("unexpected_verdict", res_id, 32'hFFFF);
          else begin
            e = sb.pop_front();
            check_val("res_id", res_id, e[IDW:1]);
            check_val("res_ok", res_ok, e[0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  initial begin
    int v0;
    string ones;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    clr_n = 1'b1;

    // 1: single string, grant latency
    @(negedge clk);
    v0 = verdicts;
    send(0, "12+3*45;", 1);
    @(negedge clk);
    check_val("t1_grant_pre", grant, 4'b0000);
    @(negedge clk);
    check_val("t1_grant", grant, 4'b0001);
    check_val("t1_busy", busy, 1);
    wait_done(200, "t1_done");
    check_val("t1_verdicts", verdicts - v0, 1);

    // 2: malformed strings from requester 2
    v0 = verdicts;
    send(2, "3+;", 1);
    send(2, ";", 1);
    send(2, "7**2;", 1);
    wait_done(300, "t2_done");
    check_val("t2_verdicts", verdicts - v0, 3);

    // 3: all requesters valid -> strict rotation from a fresh reset
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    v0 = verdicts;
    for (int i = 0; i < NREQ; i++) send(i, "1;", 1);
    send(0, "1;", 1);
    wait_done(300, "t3_done");
    check_val("t3_verdicts", verdicts - v0, 5);

    // 4: length boundary and illegal characters
    v0 = verdicts;
    ones = "";
    for (int k = 0; k < MAXLEN; k++) ones = {ones, "1"};
    send(0, {ones, ";"}, 1);
    send(0, {ones, "1;"}, 1);
    send(0, "1 2;", 1);
    send(0, "4a;", 1);
    wait_done(600, "t4_done");
    check_val("t4_verdicts", verdicts - v0, 4);

    // 5: owner stalls, another requester waits, no preemption
    v0 = verdicts;
    send(1, "9+8", 0);
    sb.push_back({2'd1, ref_ok("9+87;")});
    wait_grant(4'b0010, 20, "t5_grant1");
    send(3, "5;", 1);
    begin
      int n = 0;
      while (cq[1].size() != 0 && n < 50) begin @(negedge clk); n++; end
      check_val("t5_drained", cq[1].size(), 0);
    end
    repeat (5) begin
      @(negedge clk);
      check_val("t5_stall_grant", grant, 4'b0010);
      check_val("t5_stall_ready", req_ready, 4'b0010);
    end
    send(1, "7;", 0);
    wait_done(200, "t5_done");
    check_val("t5_verdicts", verdicts - v0, 2);

    // 6: reset mid-string drops it; requester 1 served afterwards
    send(0, "12+34;", 0);
    wait_grant(4'b0001, 20, "t6_grant0");
    repeat (2) @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    cq[0].delete();
    check_reset_vals("t6_rst");
    @(negedge clk);
    clr_n = 1'b1;
    v0 = verdicts;
    send(1, "4;", 1);
    @(negedge clk);
    @(negedge clk);
    check_val("t6_grant1", grant, 4'b0010);
    wait_done(200, "t6_done");
    check_val("t6_verdicts", verdicts - v0, 1);

    check_val("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
